// File: rtl/i2c_reg_access.sv
// i2c_reg_access: turns I2C byte-engine events into registerInterface addr/dataIn/writeEn
// accesses with an auto-incrementing register pointer, and feeds read data back as tx_data.
// Latency: write strobe 1 clk after the data byte; tx_valid RD_LATENCY+1 clks after read entry.
// Backpressure: none; the engine paces via rx_valid/tx_req pulses. Define I2C_REG_ACCESS_WDT_EN
// to build the idle watchdog that returns a stuck transfer to IDLE after TIMEOUT_CYC clks.
module i2c_reg_access #(
  parameter logic [6:0]  DEV_ADDR    = 7'h3C,
  parameter int unsigned RD_LATENCY  = 1,
  parameter logic [19:0] TIMEOUT_CYC = 20'd1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_det,
  input  logic       stop_det,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_req,
  output logic       ack_out,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic [7:0] addr,
  output logic [7:0] dataIn,
  output logic       writeEn,
  input  logic [7:0] dataOut
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DEVADR = 3'd1,
    REGPTR = 3'd2,
    WRDATA = 3'd3,
    RDWAIT = 3'd4,
    RDDATA = 3'd5,
    IGNORE = 3'd6
  } state_t;

  // Wait-counter reload value for the registerInterface read latency.
  localparam logic [7:0] RD_LAT_LD = 8'(RD_LATENCY);

  state_t     state, state_n;
  logic [7:0] ptr, ptr_n;
  logic [7:0] cnt, cnt_n;
  logic       ack_n;
  logic [7:0] tx_data_n;
  logic       tx_valid_n;
  logic [7:0] data_in_n;
  logic       write_en_n;
  logic       wdt_expired;

  // The register bus always addresses the current pointer.
  assign addr = ptr;

`ifdef I2C_REG_ACCESS_WDT_EN
  logic [19:0] wdt_cnt;
  logic        any_pulse;

  assign any_pulse   = start_det | stop_det | rx_valid | tx_req;
  assign wdt_expired = (wdt_cnt == TIMEOUT_CYC);

  // Watchdog: counts quiet cycles while a transfer is open, cleared by any engine event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdt_cnt <= '0;
    end else if (any_pulse || (state == IDLE)) begin
      wdt_cnt <= '0;
    end else if (!wdt_expired) begin
      wdt_cnt <= wdt_cnt + 20'd1;
    end
  end
`else
  logic unused_timeout;

  // Without the watchdog a transfer only ends on start_det, stop_det or reset.
  assign wdt_expired    = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  // State, pointer and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= 8'h00;
      cnt      <= 8'h00;
      ack_out  <= 1'b0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      dataIn   <= 8'h00;
      writeEn  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      cnt      <= cnt_n;
      ack_out  <= ack_n;
      tx_data  <= tx_data_n;
      tx_valid <= tx_valid_n;
      dataIn   <= data_in_n;
      writeEn  <= write_en_n;
    end
  end

  // Next-state and next-output decode; bus events are prioritised start > stop > watchdog > data.
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    cnt_n      = cnt;
    ack_n      = ack_out;
    tx_data_n  = tx_data;
    tx_valid_n = tx_valid;
    data_in_n  = dataIn;
    write_en_n = 1'b0;

    // The write strobe has just been presented at the old pointer; step to the next register.
    if (writeEn) begin
      ptr_n = ptr + 8'd1;
    end

    if (start_det) begin
      state_n    = DEVADR;
      tx_valid_n = 1'b0;
    end else if (stop_det) begin
      state_n    = IDLE;
      tx_valid_n = 1'b0;
    end else if (wdt_expired) begin
      state_n    = IDLE;
      tx_valid_n = 1'b0;
      ack_n      = 1'b0;
    end else begin
      unique case (state)
        DEVADR: begin
          if (rx_valid) begin
            if (rx_data[7:1] != DEV_ADDR) begin
              ack_n   = 1'b0;
              state_n = IGNORE;
            end else if (rx_data[0]) begin
              ack_n   = 1'b1;
              cnt_n   = RD_LAT_LD;
              state_n = RDWAIT;
            end else begin
              ack_n   = 1'b1;
              state_n = REGPTR;
            end
          end
        end

        REGPTR: begin
          if (rx_valid) begin
            ptr_n   = rx_data;
            ack_n   = 1'b1;
            state_n = WRDATA;
          end
        end

        WRDATA: begin
          if (rx_valid) begin
            data_in_n  = rx_data;
            write_en_n = 1'b1;
            ack_n      = 1'b1;
          end
        end

        RDWAIT: begin
          if (rx_valid) begin
            ack_n = 1'b0;
          end
          // dataOut for the current pointer is valid once the counter has drained.
          if (cnt == 8'h00) begin
            tx_data_n  = dataOut;
            tx_valid_n = 1'b1;
            state_n    = RDDATA;
          end else begin
            cnt_n = cnt - 8'd1;
          end
        end

        RDDATA: begin
          if (rx_valid) begin
            ack_n = 1'b0;
          end
          if (tx_req) begin
            tx_valid_n = 1'b0;
            ptr_n      = ptr + 8'd1;
            cnt_n      = RD_LAT_LD;
            state_n    = RDWAIT;
          end
        end

        IDLE, IGNORE: begin
          if (rx_valid) begin
            ack_n = 1'b0;
          end
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_access.sv
// tb_i2c_reg_access: drives engine-level events into i2c_reg_access against a register-file
// environment and checks acks, write strobes, read data and timing against a transaction model.
// Directed cases first, then randomized write/read bursts.
module tb_i2c_reg_access;

  localparam logic [6:0] DEV = 7'h3C;
  localparam int PH_IDLE = 0, PH_DEV = 1, PH_PTR = 2, PH_WR = 3, PH_RD = 4, PH_IGN = 5;

  logic       clk, reset;
  logic       start_det, stop_det, rx_valid, tx_req;
  logic [7:0] rx_data;
  logic       ack_out, tx_valid, writeEn;
  logic [7:0] tx_data, addr, dataIn, dataOut;

  logic [7:0] env_regs [256];
  logic [7:0] m_regs [256];
  logic [7:0] m_ptr;
  int         m_phase;
  logic [7:0] salt;
  int         n_cmp, n_err;

  i2c_reg_access #(
    .DEV_ADDR   (DEV),
    .RD_LATENCY (1),
    .TIMEOUT_CYC(20'd100)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start_det(start_det),
    .stop_det (stop_det),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_req   (tx_req),
    .ack_out  (ack_out),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .addr     (addr),
    .dataIn   (dataIn),
    .writeEn  (writeEn),
    .dataOut  (dataOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a * 8'd37) ^ salt ^ 8'h5A;
  endfunction

  // registerInterface stand-in: synchronous write, one-cycle registered read.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) env_regs[i] <= init_val(8'(i));
      dataOut <= 8'h00;
    end else begin
      if (writeEn) env_regs[addr] <= dataIn;
      dataOut <= env_regs[addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_regs[i] = init_val(8'(i));
    m_ptr   = 8'h00;
    m_phase = PH_IDLE;
  endtask

  task automatic do_start();
    start_det = 1'b1;
    step(1);
    start_det = 1'b0;
    m_phase = PH_DEV;
    check("start_txv", tx_valid, 0);
    check("start_wen", writeEn, 0);
    step(3);
  endtask

  task automatic do_stop();
    stop_det = 1'b1;
    step(1);
    stop_det = 1'b0;
    m_phase = PH_IDLE;
    check("stop_txv", tx_valid, 0);
    check("stop_ptr", addr, m_ptr);
    step(3);
  endtask

  // Read data must appear exactly two cycles after the block starts addressing m_ptr.
  task automatic expect_read(input string tag);
    check({tag, "_addr"}, addr, m_ptr);
    check({tag, "_lat1"}, tx_valid, 0);
    step(1);
    check({tag, "_lat2"}, tx_valid, 0);
    step(1);
    check({tag, "_vld"}, tx_valid, 1);
    check({tag, "_dat"}, tx_data, m_regs[m_ptr]);
    step(2);
  endtask

  task automatic do_txreq();
    tx_req = 1'b1;
    step(1);
    tx_req = 1'b0;
    if (m_phase == PH_RD) begin
      m_ptr = m_ptr + 8'd1;
      check("txreq_drop", tx_valid, 0);
      expect_read("rd_next");
    end else begin
      check("txreq_ign_ptr", addr, m_ptr);
      step(2);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic       exp_ack, exp_wr, rd_entry;
    logic [7:0] wa;
    exp_ack  = 1'b0;
    exp_wr   = 1'b0;
    rd_entry = 1'b0;
    wa       = m_ptr;
    case (m_phase)
      PH_DEV: begin
        if (b[7:1] != DEV) begin
          m_phase = PH_IGN;
        end else begin
          exp_ack = 1'b1;
          if (b[0]) begin
            m_phase  = PH_RD;
            rd_entry = 1'b1;
          end else begin
            m_phase = PH_PTR;
          end
        end
      end
      PH_PTR: begin
        m_ptr   = b;
        exp_ack = 1'b1;
        m_phase = PH_WR;
      end
      PH_WR: begin
        exp_wr        = 1'b1;
        exp_ack       = 1'b1;
        m_regs[m_ptr] = b;
        m_ptr         = m_ptr + 8'd1;
      end
      default: exp_ack = 1'b0;
    endcase
    rx_data  = b;
    rx_valid = 1'b1;
    step(1);
    rx_valid = 1'b0;
    check("ack", ack_out, exp_ack);
    check("wen", writeEn, exp_wr);
    if (exp_wr) begin
      check("wr_addr", addr, wa);
      check("wr_data", dataIn, b);
    end
    if (rd_entry) begin
      expect_read("rd_first");
    end else begin
      step(3);
      check("wen_clr", writeEn, 0);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    salt      = 8'($urandom);
    reset     = 1'b1;
    start_det = 1'b0;
    stop_det  = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    tx_req    = 1'b0;
    model_reset();
    step(3);

    check("rst_ack", ack_out, 0);
    check("rst_txv", tx_valid, 0);
    check("rst_txd", tx_data, 0);
    check("rst_addr", addr, 0);
    check("rst_din", dataIn, 0);
    check("rst_wen", writeEn, 0);
    reset = 1'b0;
    step(2);

    // Write burst with auto-increment.
    do_start();
    send_byte(8'h78);
    send_byte(8'h82);
    send_byte(8'h11);
    send_byte(8'h22);
    do_stop();
    check("burst_ptr", addr, 8'h84);

    // Combined-format read burst A0..A3.
    do_start();
    send_byte(8'h78);
    send_byte(8'hA0);
    do_start();
    send_byte(8'h79);
    repeat (3) do_txreq();
    check("rdburst_ptr", addr, 8'hA3);
    do_stop();

    // Read back the burst-written registers.
    do_start();
    send_byte(8'h78);
    send_byte(8'h82);
    do_start();
    send_byte(8'h79);
    check("rb_82", tx_data, 8'h11);
    do_txreq();
    check("rb_83", tx_data, 8'h22);
    do_stop();

    // Byte in IDLE is NACKed; tx_req outside a read is ignored.
    send_byte(8'h55);
    do_txreq();

    // Pointer wraps FF -> 00.
    do_start();
    send_byte(8'h78);
    send_byte(8'hFF);
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_stop();
    check("wrap_ptr", addr, 8'h01);

    // Foreign device address: NACK, no write, pointer kept.
    do_start();
    send_byte(8'h50);
    send_byte(8'h82);
    send_byte(8'h11);
    do_stop();
    check("mis_ptr", addr, 8'h01);

    // start_det beats a coincident data byte; the block is back at address decode.
    do_start();
    send_byte(8'h78);
    send_byte(8'h10);
    start_det = 1'b1;
    rx_valid  = 1'b1;
    rx_data   = 8'h99;
    step(1);
    start_det = 1'b0;
    rx_valid  = 1'b0;
    m_phase   = PH_DEV;
    check("prio_wen", writeEn, 0);
    step(1);
    check("prio_wen2", writeEn, 0);
    send_byte(8'h79);
    do_stop();

    // Reset while the write strobe is high.
    do_start();
    send_byte(8'h78);
    send_byte(8'h40);
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    step(1);
    rx_valid = 1'b0;
    check("rstw_pre_wen", writeEn, 1);
    reset = 1'b1;
    #1;
    check("rstw_wen", writeEn, 0);
    check("rstw_addr", addr, 0);
    check("rstw_ack", ack_out, 0);
    check("rstw_txd", tx_data, 0);
    check("rstw_din", dataIn, 0);
    step(2);
    reset = 1'b0;
    model_reset();
    step(2);
    do_start();
    send_byte(8'h78);
    send_byte(8'h40);
    do_start();
    send_byte(8'h79);
    do_stop();

    // Randomized bursts, some starting near the wrap point.
    for (int t = 0; t < 10; t++) begin
      logic [7:0] p;
      int         n;
      p = 8'($urandom_range(0, 255));
      if ((t % 3) == 0) p = 8'hFE;
      n = $urandom_range(1, 4);
      do_start();
      send_byte({DEV, 1'b0});
      send_byte(p);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < n; k++) send_byte(8'($urandom));
      end else begin
        do_start();
        send_byte({DEV, 1'b1});
        for (int k = 0; k < n; k++) do_txreq();
      end
      do_stop();
    end

    // Master stalls mid-read.
    do_start();
    send_byte(8'h79);
    step(120);
`ifdef I2C_REG_ACCESS_WDT_EN
    check("wdt_txv", tx_valid, 0);
`else
    check("wdt_txv", tx_valid, 1);
`endif
    do_stop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
